// File: rtl/bias_add_0_if.sv
// FIFO-style stream bundle for bias_add_0: bias and accumulator read ports plus
// the result write port. The master side feeds/absorbs the streams, the slave side is the block.
interface bias_add_0_if #(
    parameter int COEFF_W = 16,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 16
);
    logic [COEFF_W-1:0] bias_V_dout;
    logic               bias_V_empty_n;
    logic               bias_V_read;
    logic [ACC_W-1:0]   acc_V_dout;
    logic               acc_V_empty_n;
    logic               acc_V_read;
    logic [OUT_W-1:0]   output_V_din;
    logic               output_V_full_n;
    logic               output_V_write;

    modport master (
        output bias_V_dout, bias_V_empty_n, input bias_V_read,
        output acc_V_dout, acc_V_empty_n, input acc_V_read,
        input output_V_din, output_V_write, output output_V_full_n
    );

    modport slave (
        input bias_V_dout, bias_V_empty_n, output bias_V_read,
        input acc_V_dout, acc_V_empty_n, output acc_V_read,
        output output_V_din, output_V_write, input output_V_full_n
    );
endinterface

// File: rtl/bias_add_0.sv
// Layer-0 bias adder: loads KERN biases per frame, then adds the per-channel bias
// to each accumulator word, applies optional ReLU, saturates and streams out.
module bias_add_0 #(
    parameter int KERN       = 16,
    parameter int COEFF_W    = 16,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 16,
    parameter int BIAS_SHIFT = 0,
    parameter int PIX_N      = 1024,
    parameter int RELU       = 1
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    bias_add_0_if.slave  io
);
    localparam int CH_W  = (KERN > 1) ? $clog2(KERN) : 1;
    localparam int PIX_W = (PIX_N > 1) ? $clog2(PIX_N) : 1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(KERN - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_N - 1);
    localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t                    state_q, state_d;
    logic [CH_W-1:0]           ch_cnt_q, ch_cnt_d;
    logic [PIX_W-1:0]          pix_cnt_q, pix_cnt_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]   dout_q, dout_d;
    logic signed [COEFF_W-1:0] bias_q [KERN];

    logic                      bias_pop, acc_pop, out_push;
    logic signed [ACC_W:0]     bias_ext, acc_ext, sum;

    function automatic logic signed [OUT_W-1:0] relu_sat(input logic signed [ACC_W:0] s);
        logic signed [ACC_W:0] r;
        r = s;
        if (RELU != 0 && r[ACC_W]) r = '0;
        if (r > OUT_MAX) return OUT_MAX[OUT_W-1:0];
        if (r < OUT_MIN) return OUT_MIN[OUT_W-1:0];
        return r[OUT_W-1:0];
    endfunction

    // Handshake outputs; held low while reset is asserted, without waiting for a clock.
    always_comb begin
        bias_pop = 1'b0;
        acc_pop  = 1'b0;
        out_push = ap_rst_n & out_valid_q & io.output_V_full_n;
        case (state_q)
            ST_LOAD: bias_pop = ap_rst_n & io.bias_V_empty_n;
            ST_RUN:  acc_pop  = ap_rst_n & io.acc_V_empty_n & (~out_valid_q | io.output_V_full_n);
            default: ;
        endcase
    end

    assign io.bias_V_read    = bias_pop;
    assign io.acc_V_read     = acc_pop;
    assign io.output_V_write = out_push;
    assign io.output_V_din   = dout_q;

    always_comb begin
        state_d   = state_q;
        ch_cnt_d  = ch_cnt_q;
        pix_cnt_d = pix_cnt_q;
        case (state_q)
            ST_LOAD: begin
                if (bias_pop) begin
                    if (ch_cnt_q == CH_LAST) begin
                        ch_cnt_d = '0;
                        state_d  = ST_RUN;
                    end else begin
                        ch_cnt_d = ch_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (acc_pop) begin
                    if (ch_cnt_q == CH_LAST) begin
                        ch_cnt_d = '0;
                        if (pix_cnt_q == PIX_LAST) begin
                            pix_cnt_d = '0;
                            state_d   = ST_LOAD;
                        end else begin
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end
                    end else begin
                        ch_cnt_d = ch_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Sum is one bit wider than the accumulator so the bias add cannot wrap.
    always_comb begin
        bias_ext = (ACC_W+1)'(bias_q[ch_cnt_q]);
        acc_ext  = (ACC_W+1)'($signed(io.acc_V_dout));
        sum      = acc_ext + (bias_ext <<< BIAS_SHIFT);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        if (acc_pop) begin
            out_valid_d = 1'b1;
            dout_d      = relu_sat(sum);
        end else if (out_push) begin
            out_valid_d = 1'b0;
        end
    end

    // Stage boundary: control state and the output register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ST_LOAD;
            ch_cnt_q    <= '0;
            pix_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            ch_cnt_q    <= ch_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
        end
    end

    // Bias register file is fully rewritten each frame before use, so it has no reset.
    always_ff @(posedge ap_clk) begin
        if (bias_pop) bias_q[ch_cnt_q] <= $signed(io.bias_V_dout);
    end
endmodule

// File: tb/tb_bias_add_0.sv
// Directed bench for bias_add_0 (KERN=4, PIX_N=2) with a ReLU and a non-ReLU instance
// fed from the same FIFO model and checked against queued expected words.
module tb_bias_add_0;
    localparam int KERN = 4, PIX_N = 2, COEFF_W = 16, ACC_W = 32, OUT_W = 16;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    bias_add_0_if #(.COEFF_W(COEFF_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) if_a ();
    bias_add_0_if #(.COEFF_W(COEFF_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) if_b ();

    assign if_b.bias_V_dout     = if_a.bias_V_dout;
    assign if_b.bias_V_empty_n  = if_a.bias_V_empty_n;
    assign if_b.acc_V_dout      = if_a.acc_V_dout;
    assign if_b.acc_V_empty_n   = if_a.acc_V_empty_n;
    assign if_b.output_V_full_n = if_a.output_V_full_n;

    bias_add_0 #(.KERN(KERN), .COEFF_W(COEFF_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
                 .BIAS_SHIFT(0), .PIX_N(PIX_N), .RELU(1))
        u_dut (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .io(if_a.slave));

    bias_add_0 #(.KERN(KERN), .COEFF_W(COEFF_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
                 .BIAS_SHIFT(0), .PIX_N(PIX_N), .RELU(0))
        u_dut_nr (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .io(if_b.slave));

    int tests_run = 0;
    int tests_failed = 0;
    int bq[$], aq[$], eqa[$], eqb[$], popcyc[$];
    int fb[4], fa[8], ea[8], eb[8];
    int cyc = 0, acc_pops = 0;
    bit rnd_b = 0, rnd_a = 0, lat_on = 1;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_out(input int acc, input int bias, input bit relu);
        longint s;
        s = longint'(acc) + longint'(bias);
        if (relu && s < 0) s = 0;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    function automatic void fill_model();
        for (int i = 0; i < 8; i++) begin
            ea[i] = ref_out(fa[i], fb[i % KERN], 1'b1);
            eb[i] = ref_out(fa[i], fb[i % KERN], 1'b0);
        end
    endfunction

    task automatic push_bias();
        for (int c = 0; c < KERN; c++) bq.push_back(fb[c]);
    endtask

    task automatic push_acc_exp();
        for (int i = 0; i < 8; i++) begin
            aq.push_back(fa[i]);
            eqa.push_back(ea[i]);
            eqb.push_back(eb[i]);
        end
    endtask

    // One clock: drive FIFO fronts at negedge, then account for the handshakes
    // that will complete at the following posedge.
    task automatic step(input bit full_n);
        @(negedge ap_clk);
        cyc++;
        if_a.bias_V_empty_n  = (bq.size() > 0) && (!rnd_b || $urandom_range(0, 2) != 0);
        if_a.bias_V_dout     = (bq.size() > 0) ? COEFF_W'(bq[0]) : COEFF_W'($urandom);
        if_a.acc_V_empty_n   = (aq.size() > 0) && (!rnd_a || $urandom_range(0, 2) != 0);
        if_a.acc_V_dout      = (aq.size() > 0) ? ACC_W'(aq[0]) : ACC_W'($urandom);
        if_a.output_V_full_n = full_n;
        #1;
        if (if_a.output_V_write) begin
            if (eqa.size() == 0) check("out_a_extra", 1, 0);
            else begin
                check("out_a", $signed(if_a.output_V_din), eqa.pop_front());
                if (lat_on && popcyc.size() > 0) check("latency", cyc - popcyc[0], 1);
            end
            if (popcyc.size() > 0) void'(popcyc.pop_front());
        end
        if (if_b.output_V_write) begin
            if (eqb.size() == 0) check("out_b_extra", 1, 0);
            else check("out_b", $signed(if_b.output_V_din), eqb.pop_front());
        end
        if (if_a.bias_V_read) begin
            check("bias_rd_gate", if_a.bias_V_empty_n, 1);
            if (bq.size() > 0) void'(bq.pop_front());
        end
        if (if_a.acc_V_read) begin
            check("acc_rd_gate", if_a.acc_V_empty_n, 1);
            if (aq.size() > 0) void'(aq.pop_front());
            popcyc.push_back(cyc);
            acc_pops++;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((eqa.size() > 0 || eqb.size() > 0) && n < budget) begin
            step(1'b1);
            n++;
        end
        check("drain_left", eqa.size() + eqb.size(), 0);
    endtask

    task automatic idle_inputs();
        if_a.bias_V_empty_n = 1'b0;
        if_a.acc_V_empty_n  = 1'b0;
    endtask

    initial begin
        int start, n;
        logic [OUT_W-1:0] hold;
        if_a.bias_V_dout = '0;
        if_a.acc_V_dout = '0;
        if_a.output_V_full_n = 1'b1;
        idle_inputs();

        // T1: reset with random inputs
        repeat (4) begin
            @(negedge ap_clk);
            if_a.bias_V_dout     = COEFF_W'($urandom);
            if_a.bias_V_empty_n  = 1'($urandom);
            if_a.acc_V_dout      = $urandom;
            if_a.acc_V_empty_n   = 1'($urandom);
            if_a.output_V_full_n = 1'($urandom);
            #1;
            check("rst_bias_rd", if_a.bias_V_read, 0);
            check("rst_acc_rd", if_a.acc_V_read, 0);
            check("rst_wr", if_a.output_V_write, 0);
            check("rst_din", if_a.output_V_din, 0);
            check("rst_din_b", if_b.output_V_din, 0);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        if_a.bias_V_empty_n = 1'b1;
        if_a.acc_V_empty_n = 1'b1;
        if_a.output_V_full_n = 1'b1;
        #1;
        check("rel_bias_rd_hi", if_a.bias_V_read, 1);
        check("rel_acc_rd_load", if_a.acc_V_read, 0);
        check("rel_wr", if_a.output_V_write, 0);
        if_a.bias_V_empty_n = 1'b0;
        #1;
        check("rel_bias_rd_lo", if_a.bias_V_read, 0);
        idle_inputs();

        // T2: basic frame, then the block must return to LOAD
        fb = '{10, -5, 0, 7};
        fa = '{100, 101, 102, 103, 104, 105, 106, 107};
        ea = '{110, 96, 102, 110, 114, 100, 106, 114};
        eb = ea;
        push_bias();
        push_acc_exp();
        drain(60);
        fb = '{1, 2, 3, 4};
        fa = '{0, 1, 2, 3, 4, 5, 6, 7};
        ea = '{1, 3, 5, 7, 5, 7, 9, 11};
        eb = ea;
        push_acc_exp();
        repeat (4) step(1'b1);
        check("load_holds_acc", aq.size(), 8);
        push_bias();
        drain(60);

        // T3: ReLU and saturation, both instances
        fb = '{10, 100, 0, 0};
        fa = '{-50, 32'h7FFFFFF0, 5, -5, -10, -100, 40000, -40000};
        ea = '{0, 32767, 5, 0, 0, 0, 32767, 0};
        eb = '{-40, 32767, 5, -5, 0, 0, 32767, -32768};
        push_bias();
        push_acc_exp();
        drain(60);

        // T4: output backpressure for 5 cycles mid-stream
        fb = '{3, -3, 1000, -1000};
        fa = '{20, 40, 60, 80, -100, 200, 31000, -300};
        fill_model();
        lat_on = 0;
        push_bias();
        push_acc_exp();
        start = acc_pops;
        n = 0;
        while (acc_pops - start < 3 && n < 50) begin
            step(1'b1);
            n++;
        end
        hold = '0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0);
            if (k == 0) hold = if_a.output_V_din;
            else check("bp_din_stable", if_a.output_V_din, hold);
            check("bp_no_write", if_a.output_V_write, 0);
            check("bp_acc_stall", if_a.acc_V_read, 0);
        end
        drain(60);
        lat_on = 1;

        // T5: random starvation on both input FIFOs, three frames
        rnd_b = 1;
        rnd_a = 1;
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < KERN; c++) fb[c] = int'($urandom_range(0, 4000)) - 2000;
            for (int i = 0; i < 8; i++) begin
                fa[i] = int'($urandom_range(0, 100000)) - 50000;
                if ($urandom_range(0, 3) == 0) fa[i] = int'($urandom);
            end
            fill_model();
            push_bias();
            push_acc_exp();
        end
        drain(400);
        rnd_b = 0;
        rnd_a = 0;

        // T6: asynchronous reset in the middle of RUN
        fb = '{5, 6, 7, 8};
        fa = '{1000, 1001, 1002, 1003, 1004, 1005, 1006, 1007};
        fill_model();
        push_bias();
        push_acc_exp();
        start = acc_pops;
        n = 0;
        while (acc_pops - start < 5 && n < 50) begin
            step(1'b1);
            n++;
        end
        ap_rst_n = 1'b0;
        idle_inputs();
        #1;
        check("arst_wr", if_a.output_V_write, 0);
        check("arst_din", if_a.output_V_din, 0);
        check("arst_din_b", if_b.output_V_din, 0);
        check("arst_acc_rd", if_a.acc_V_read, 0);
        check("arst_bias_rd", if_a.bias_V_read, 0);
        bq.delete();
        aq.delete();
        eqa.delete();
        eqb.delete();
        popcyc.delete();
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        fb = '{-7, 9, -11, 13};
        fa = '{-3, 50, 2000, -20, 7, -9, 11, 40000};
        fill_model();
        push_bias();
        push_acc_exp();
        drain(60);
        fb = '{300, -300, 1, -1};
        fa = '{32700, -32700, 0, 5, -1, 1, 123456, -123456};
        fill_model();
        push_bias();
        push_acc_exp();
        drain(60);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
